instr_data_mem_responder: RTL and testbench
===========================================

Name: instr_data_mem_responder

Overview:
- Memory-side responder for the core's request/response bus.
- The core's fetch and load/store datapath act as initiator; this block is the other end: it accepts one request, waits a fixed latency, then returns read data or a write acknowledge.
- Replaces the current zero-latency memory array so the control FSM can be exercised against realistic wait states.
- Word-addressed storage, byte-lane writes, error response for bad accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; word index = req_addr[31:2].
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15. Elaboration error outside this range.
- ROM_WORDS, 256, words 0..ROM_WORDS-1 are text region. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i enables byte i, little-endian.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  access fault.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; latency counter=0.
  - Any in-flight transaction is dropped with no write. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N: latch addr, we, wdata, be; counter=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter==0, go to RESP at the next edge (edge N+LATENCY). Otherwise decrement.
- Commit on entry to RESP (same edge):
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Read: rsp_rdata = M[idx].
  - Write: bytes with be=1 are updated; rsp_rdata=0.
  - Error: no memory change; rsp_rdata=0; rsp_err=1.
  - A write with be=4'b0000 is legal: no change, no error.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake: go to IDLE; rsp_valid, rsp_rdata and rsp_err all clear to 0.
- Throughput: no back-to-back acceptance; the minimum request-to-request spacing is LATENCY+2 cycles with rsp_ready held at 1.
- Request inputs are ignored when req_ready=0; the initiator must hold its request until accepted.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely, with outputs stable.
- Read-after-write to the same word returns the newly written data.
- Reset asserted in WAIT or RESP returns the block to IDLE at that edge; a write not yet committed is lost.

Optional Feature:
- Macro MEM_TEXT_WRITE_PROTECT_EN.
- Defined: a write whose word index is < ROM_WORDS and whose req_be!=0 is an error (rsp_err=1, memory unchanged). Reads there are normal.
- Undefined: ROM_WORDS is unused and the whole array is writable.

Test Plan:
- Read, LATENCY=2: preload M[0]=32'h010000EF; request read addr 0x0 accepted at edge N -> rsp_valid=1 after edge N+2; rsp_rdata=32'h010000EF, rsp_err=0; req_ready=0 from after edge N until IDLE re-entry.
- Byte-lane write: M[5]=32'h11223344; write addr 0x14, wdata 32'hAABBCCDD, be=4'b0101 -> write ack with rsp_rdata=0, err=0; subsequent read of 0x14 returns 32'h11BB33DD.
- Errors: read 0x2 -> rsp_err=1, rdata=0; write 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, and M is unchanged on readback of in-range words.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout; a req_valid pulse during this time is ignored; the next request is accepted only after the rsp handshake plus return to IDLE.
- Reset mid-operation: accept write 32'hDEADBEEF to 0x8, assert reset (0) during WAIT -> next cycle req_ready=1, rsp_valid=0; read of 0x8 returns the old value.
- With MEM_TEXT_WRITE_PROTECT_EN defined and ROM_WORDS=256: write to 0x10 -> rsp_err=1, M[4] unchanged. Write to 0x400 (word 256) -> err=0, data written.

Source files
------------

// File: rtl/instr_data_mem_responder_if.sv
// rtl/instr_data_mem_responder_if.sv - request/response bus between core initiator and memory responder
interface instr_data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/instr_data_mem_responder.sv
// rtl/instr_data_mem_responder.sv - fixed-latency word memory responder with byte-lane writes and error response
// Optional text-region write protection: define MEM_TEXT_WRITE_PROTECT_EN.
module instr_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ROM_WORDS   = 256
) (
  input logic                       clk,
  input logic                       reset,
  instr_data_mem_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("LATENCY must be in 1..15");
    end
    if (ROM_WORDS < 0 || ROM_WORDS > DEPTH_WORDS) begin : g_bad_rom
      $error("ROM_WORDS must be in 0..DEPTH_WORDS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             range_err;
  logic             wp_err;
  logic             acc_err;
  logic             commit;

  assign idx       = addr_q[IDX_W+1:2];
  assign range_err = (addr_q[1:0] != 2'b00) ||
                     ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

`ifdef MEM_TEXT_WRITE_PROTECT_EN
  // An all-zero byte enable changes nothing, so it is allowed even in the text region.
  assign wp_err = we_q && (be_q != 4'b0000) &&
                  ({2'b00, addr_q[31:2]} < 32'(ROM_WORDS));
`else
  assign wp_err = 1'b0;
`endif

  assign acc_err = range_err || wp_err;
  // Commit happens on the edge that enters RESP; a reset on that edge drops the write.
  assign commit  = reset && (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            addr_q        <= bus.req_addr;
            we_q          <= bus.req_we;
            wdata_q       <= bus.req_wdata;
            be_q          <= bus.req_be;
            cnt           <= 4'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err;
            bus.rsp_rdata <= (we_q || acc_err) ? 32'h0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_data_mem_responder.sv
// tb/tb_instr_data_mem_responder.sv - directed vector bench for instr_data_mem_responder
module tb_instr_data_mem_responder;
  localparam int LATENCY = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_data_mem_responder_if bus();

  instr_data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(LATENCY),
    .ROM_WORDS(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  vec_t vecs[20];
  int n_tab = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    vecs[n_tab] = '{we, addr, wdata, be, exp_rdata, exp_err};
    n_tab++;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int t = 0;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.req_ready !== 1'b0) check({name, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic txn(input string name, input vec_t v);
    int lat;
    bus.rsp_ready = 1'b1;
    issue(v.we, v.addr, v.wdata, v.be);
    wait_rsp(name, lat);
    check({name, "_latency"}, 32'(lat), 32'(LATENCY));
    check({name, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({name, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    @(negedge clk);
    check({name, "_idle"}, {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    vec_t v;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b1;

`ifdef MEM_TEXT_WRITE_PROTECT_EN
    add(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    add(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
    add(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    add(1'b0, 32'h0000_0002, 32'h0,         4'h0, 32'h0, 1'b1);
`else
    add(1'b1, 32'h0000_0000, 32'h0100_00EF, 4'hF, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0100_00EF, 1'b0);
    add(1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    add(1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
    add(1'b0, 32'h0000_0002, 32'h0,         4'h0, 32'h0, 1'b1);
    add(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    add(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0100_00EF, 1'b0);
    add(1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
    add(1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h5A5A_5A5A, 1'b0);
    add(1'b0, 32'h0000_0FFE, 32'h0,         4'h0, 32'h0, 1'b1);
    add(1'b1, 32'h0000_0016, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
    add(1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("reset_state", {28'h0, bus.req_ready, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'h8);
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < n_tab; i++) begin
      txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: response held, stray request ignored.
    v = '{1'b1, 32'h0000_0420, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    txn("bp_setup", v);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0420, 32'h0, 4'h0);
    wait_rsp("bp", lat);
    check("bp_latency", 32'(lat), 32'(LATENCY));
    held = bus.rsp_rdata;
    check("bp_rdata", held, 32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.req_we = 1'b1; bus.req_addr = 32'h0000_0420;
        bus.req_wdata = 32'h0; bus.req_be = 4'hF; bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp_hold%0d", c),
            {bus.rsp_valid, bus.req_ready, bus.rsp_err, 29'h0}, 32'h8000_0000);
      check($sformatf("bp_rdata%0d", c), bus.rsp_rdata, held);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {28'h0, bus.req_ready, bus.rsp_valid, 2'b0}, 32'h8);
    check("bp_release_rdata", bus.rsp_rdata, 32'h0);
    v = '{1'b0, 32'h0000_0420, 32'h0, 4'h0, 32'h1234_5678, 1'b0};
    txn("bp_reread", v);

    // Reset during WAIT drops the pending write.
    v = '{1'b1, 32'h0000_0408, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0};
    txn("rst_setup", v);
    issue(1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 4'hF);
    check("rst_in_wait", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", {28'h0, bus.req_ready, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'h8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_quiet", 32'(bus.rsp_valid), 32'd0);
    v = '{1'b0, 32'h0000_0408, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0};
    txn("rst_reread", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
